// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, fixed word length, single chip select.
// Optional back-to-back bursts with CS held low: define SPI_MASTER_BURST_EN.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  CLK_50,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  CS,
  output logic                  SPI_CLK,
  output logic                  SPI_outgoing,
  input  logic                  SPI_incoming
);

  // state | meaning
  // IDLE  | CS high, waiting for tx_valid (tx_ready high)
  // SETUP | CS low, MSB on MOSI, SCK low for CLK_DIV cycles
  // SHIFT | DATA_WIDTH SCK pulses, CLK_DIV cycles per phase
  // HOLD  | CS still low after the last falling edge, CLK_DIV cycles
  // GAP   | CS high, inter-word spacing before IDLE
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(DATA_WIDTH - 1);

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_ready     <= 1'b0;
      CS           <= 1'b1;
      SPI_CLK      <= 1'b0;
      SPI_outgoing <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_ready     <= 1'b0;
            tx_sh        <= tx_data;
            SPI_outgoing <= tx_data[DATA_WIDTH-1];
            CS           <= 1'b0;
            cnt          <= CNT_LOAD;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            SPI_CLK <= 1'b1;
            cnt     <= CNT_LOAD;
            bit_cnt <= BIT_LOAD;
            state   <= SHIFT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SHIFT: begin
          // first cycle of each high phase captures MISO
          if (SPI_CLK && cnt == CNT_LOAD)
            rx_sh <= {rx_sh[DATA_WIDTH-2:0], SPI_incoming};
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt <= CNT_LOAD;
            if (!SPI_CLK) begin
              SPI_CLK <= 1'b1;
            end else begin
              SPI_CLK <= 1'b0;
              if (bit_cnt == '0) begin
                state    <= HOLD;
                tx_ready <= BURST_EN && (CLK_DIV == 1);
              end else begin
                bit_cnt      <= bit_cnt - BW'(1);
                tx_sh        <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
                SPI_outgoing <= tx_sh[DATA_WIDTH-2];
              end
            end
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            // burst: open the acceptance window on the last HOLD cycle
            if (BURST_EN && cnt == CW'(1))
              tx_ready <= 1'b1;
          end else begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            tx_ready <= 1'b0;
            cnt      <= CNT_LOAD;
            if (BURST_EN && tx_valid && tx_ready) begin
              tx_sh        <= tx_data;
              SPI_outgoing <= tx_data[DATA_WIDTH-1];
              state        <= SETUP;
            end else begin
              CS    <= 1'b1;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance with a mode-0 slave model,
// plus a CLK_DIV=1 / DATA_WIDTH=16 instance. Burst case when SPI_MASTER_BURST_EN is set.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0, tx_valid0, tx_ready0, rx_valid0, cs0, sck0, mosi0, miso0;
  logic [7:0] tx_data0, rx_data0;
  logic        rst1, tx_valid1, tx_ready1, rx_valid1, cs1, sck1, mosi1, miso1;
  logic [15:0] tx_data1, rx_data1;

  spi_master u0 (
    .CLK_50(clk), .RST(rst0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .CS(cs0), .SPI_CLK(sck0),
    .SPI_outgoing(mosi0), .SPI_incoming(miso0)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) u1 (
    .CLK_50(clk), .RST(rst1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .CS(cs1), .SPI_CLK(sck1),
    .SPI_outgoing(mosi1), .SPI_incoming(miso1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // slave model and event recorder for u0 (sampled on the falling clock edge)
  logic       prev_sck0 = 1'b0, prev_cs0 = 1'b1;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] slave_word = 8'h3C;
  logic [15:0] mosi_bits = '0;
  int rise_n = 0, rxv_n = 0, viol = 0, gap_n = 0, cs_rise_t = 0;
  int rise_t[16];
  int rxv_t[8];
  logic [7:0] rxv_d[8];
  int gaps[16];

  always @(negedge clk) begin
    if (!cs0 && prev_cs0) begin
      sl_sh = slave_word;
      if (gap_n < 16) gaps[gap_n] = cyc - cs_rise_t;
      gap_n++;
    end else if (!sck0 && prev_sck0) begin
      sl_sh = {sl_sh[6:0], 1'b0};
    end
    if (cs0 && !prev_cs0) cs_rise_t = cyc;
    miso0 = sl_sh[7];
    if (sck0 && !prev_sck0) begin
      if (rise_n < 16) rise_t[rise_n] = cyc;
      mosi_bits = {mosi_bits[14:0], mosi0};
      rise_n++;
    end
    if (rx_valid0) begin
      if (rxv_n < 8) begin
        rxv_t[rxv_n] = cyc;
        rxv_d[rxv_n] = rx_data0;
      end
      rxv_n++;
    end
    if (tx_ready0 && !cs0) viol++;
    prev_sck0 = sck0;
    prev_cs0  = cs0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic run_u1(input logic [15:0] d, input logic m, input logic [15:0] exp_rx);
    int   rises = 0;
    int   tog_err = 0;
    logic prev = 1'b0;
    logic exp_sck;
    tx_data1 = d; tx_valid1 = 1'b1; miso1 = m;
    check("u1_ready", tx_ready1, 1);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) begin
        tx_valid1 = 1'b0;
        check("u1_cs_t1", cs1, 0);
      end
      // rising edge k at T0+2+2k, one cycle high each
      exp_sck = (t >= 2 && t <= 33 && (t % 2 == 0));
      if (sck1 !== exp_sck) tog_err++;
      if (sck1 && !prev) rises++;
      prev = sck1;
      if (t == 33) check("u1_cs_33", cs1, 0);
      if (t == 34) begin
        check("u1_cs_34", cs1, 1);
        check("u1_rxv_34", rx_valid1, 1);
        check("u1_rxd_34", rx_data1, exp_rx);
      end
    end
    check("u1_rises", rises, 16);
    check("u1_toggle", tog_err, 0);
  endtask

  initial begin
    int t0, cs_err, base_rxv, base_gap, base_viol, rdy_t, rp;
    logic got;
    rst0 = 1'b1; rst1 = 1'b1;
    tx_valid0 = 1'b0; tx_data0 = '0;
    tx_valid1 = 1'b0; tx_data1 = '0; miso1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs0, 1);
    check("rst_ready", tx_ready0, 0);
    check("rst_sck", sck0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_rxd", rx_data0, 0);
    check("rst_rxv", rx_valid0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready0, 1);

    // default transfer 0xA5 against slave returning 0x3C
    tx_data0 = 8'hA5; tx_valid0 = 1'b1; t0 = cyc;
    check("t1_accept", tx_ready0, 1);
    @(negedge clk);
    tx_valid0 = 1'b0; tx_data0 = 8'h0F;
    check("t1_cs_t1", cs0, 0);
    check("t1_mosi_msb", mosi0, 1);
    check("t1_ready_t1", tx_ready0, 0);
    cs_err = 0;
    for (int t = 2; t <= 75; t++) begin
      @(negedge clk);
      if (t <= 68 && cs0 !== 1'b0) cs_err++;
      if (t <= 68 && rx_valid0 !== 1'b0) cs_err++;
      if (t == 69) begin
        check("t1_cs_69", cs0, 1);
        check("t1_rxv_69", rx_valid0, 1);
        check("t1_rxd_69", rx_data0, 8'h3C);
      end
      if (t == 70) check("t1_rxv_70", rx_valid0, 0);
      if (t == 72) check("t1_ready_72", tx_ready0, 0);
      if (t == 73) check("t1_ready_73", tx_ready0, 1);
    end
    check("t1_cs_low_span", cs_err, 0);
    check("t1_rise_n", rise_n, 8);
    for (int k = 0; k < 8; k++) check("t1_rise_t", rise_t[k], t0 + 5 + 8 * k);
    check("t1_mosi_bits", mosi_bits[7:0], 8'hA5);
    check("t1_rxv_n", rxv_n, 1);
    check("t1_rxv_t", rxv_t[0], t0 + 69);
    check("t1_rxd_hold", rx_data0, 8'h3C);

    // CLK_DIV=1, DATA_WIDTH=16: first all-ones MISO, then the all-zeros vector
    run_u1(16'h0000, 1'b1, 16'hFFFF);
    run_u1(16'hFFFF, 1'b0, 16'h0000);

    // reset in the middle of a default transfer
    base_rxv = rxv_n;
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) tx_valid0 = 1'b0;
      if (t == 30) begin
        check("t3_sck_30", sck0, 1);
        rst0 = 1'b1;
      end
      if (t == 31) begin
        check("t3_cs_31", cs0, 1);
        check("t3_sck_31", sck0, 0);
        check("t3_ready_31", tx_ready0, 0);
        rst0 = 1'b0;
      end
      if (t == 32) check("t3_ready_32", tx_ready0, 1);
    end
    check("t3_no_rxv", rxv_n, base_rxv);
    check("t3_rxd_kept", rx_data0, 8'h00);

`ifndef SPI_MASTER_BURST_EN
    // tx_valid held high: CS-high span between words is GAP plus the IDLE accept cycle
    base_gap = gap_n; base_viol = viol;
    tx_data0 = 8'h5A; tx_valid0 = 1'b1;
    repeat (240) @(negedge clk);
    tx_valid0 = 1'b0;
    repeat (80) @(negedge clk);
    check("t4_words", gap_n - base_gap, 4);
    for (int k = 1; k < 4; k++) check("t4_gap", gaps[base_gap + k], 5);
    check("t4_ready_while_cs", viol - base_viol, 0);
`else
    // burst: 0x12 then 0x34 with CS held low between them
    base_rxv = rxv_n; base_viol = viol;
    tx_data0 = 8'h12; tx_valid0 = 1'b1; t0 = cyc;
    got = 1'b0; rdy_t = 0; rp = 0; cs_err = 0;
    for (int t = 1; t <= 150; t++) begin
      @(negedge clk);
      if (t == 1) tx_valid0 = 1'b0;
      if (got && t == rdy_t + 1) tx_valid0 = 1'b0;
      if (tx_ready0 && !cs0) rp++;
      if (tx_ready0 && !got && t < 100) begin
        got = 1'b1; rdy_t = t;
        tx_data0 = 8'h34; tx_valid0 = 1'b1;
      end
      if (t <= 136 && cs0 !== 1'b0) cs_err++;
      if (t == 137) check("t5_cs_137", cs0, 1);
      if (t == 140) check("t5_ready_140", tx_ready0, 0);
      if (t == 141) check("t5_ready_141", tx_ready0, 1);
    end
    check("t5_window_found", got, 1);
    check("t5_window_t", rdy_t, 68);
    check("t5_ready_pulses", rp, 1);
    check("t5_cs_low", cs_err, 0);
    check("t5_rxv_n", rxv_n - base_rxv, 2);
    check("t5_rxv_t0", rxv_t[base_rxv], t0 + 69);
    check("t5_rxv_space", rxv_t[base_rxv + 1] - rxv_t[base_rxv], 68);
    check("t5_rxd0", rxv_d[base_rxv], 8'h3C);
    check("t5_rxd1", rxv_d[base_rxv + 1], 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
